// File: rtl/pmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_pkg
//  Purpose  : Shared constants and types for the pmem line responder.
//             LINE_W   - width of one cache line in bits
//             OFFSET_W - byte-offset bits inside a line (ignored by the slave)
//  Revision : 1.0 - initial release
// ============================================================================
package pmem_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

  typedef logic [LINE_W-1:0] pmem_line_t;

endpackage
`default_nettype wire

// File: rtl/pmem_line_array.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_line_array
//  Purpose  : NUM_LINES x LINE_W backing store, synchronous write and
//             combinational read. Contents are deliberately not reset.
//  Ports    : clk   - clock
//             we    - write enable (commit on rising edge)
//             widx  - write line index
//             wdata - write line data
//             ridx  - read line index
//             rdata - read line data (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module pmem_line_array
  import pmem_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(NUM_LINES)-1:0] widx,
  input  logic [LINE_W-1:0]            wdata,
  input  logic [$clog2(NUM_LINES)-1:0] ridx,
  output logic [LINE_W-1:0]            rdata
);

  logic [LINE_W-1:0] mem_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];

endmodule
`default_nettype wire

// File: rtl/pmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_responder
//  Purpose  : Slave end of the 256-bit pmem line interface. Accepts one line
//             read or write at a time, holds it for a fixed per-op latency and
//             answers with a one-cycle pmem_resp.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             pmem_address  - byte address, bits [4:0] ignored
//             pmem_wdata    - write line
//             pmem_read     - read request (level)
//             pmem_write    - write request (level)
//             pmem_rdata    - registered read line
//             pmem_resp     - one-cycle completion pulse
//             rd_count      - completed reads (wraps)
//             wr_count      - completed writes (wraps)
//             proto_err     - sticky protocol-violation flag
//  Revision : 1.0 - initial release
// ============================================================================
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int NUM_LINES     = 16,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_read,
  input  logic              pmem_write,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic              proto_err
);

  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       req_q, req_d;      // raw {read, write} as accepted
  logic [IDX_W-1:0] idx_q, idx_d;
  pmem_line_t       wdata_q, wdata_d;
  pmem_line_t       rdata_q, rdata_d;
  logic [31:0]      rd_cnt_q, rd_cnt_d;
  logic [31:0]      wr_cnt_q, wr_cnt_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] addr_idx;
  logic [IDX_W-1:0] ridx;
  pmem_line_t       arr_rdata;
  logic             arr_we;
  logic             op_write;

  // Offset bits and aliasing upper bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pmem_address[31:OFFSET_W+IDX_W], pmem_address[OFFSET_W-1:0]};

  assign addr_idx = pmem_address[OFFSET_W +: IDX_W];
  // Write wins when both request lines are high.
  assign op_write = req_q[0];
  // In IDLE a latency-1 read must fetch the incoming index directly.
  assign ridx     = (state_q == ST_IDLE) ? addr_idx : idx_q;

  pmem_line_array #(
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .ridx  (ridx),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    arr_we   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pmem_read || pmem_write) begin
          req_d   = {pmem_read, pmem_write};
          idx_d   = addr_idx;
          wdata_d = pmem_wdata;
          if (pmem_read && pmem_write) begin
            err_d = 1'b1;
          end
          if (pmem_write ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1)) begin
            state_d = ST_RESP;
            if (!pmem_write) begin
              rdata_d = arr_rdata;
            end
          end else begin
            state_d = ST_BUSY;
            cnt_d   = pmem_write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
          end
        end
      end

      ST_BUSY: begin
        if (({pmem_read, pmem_write} != req_q) || (addr_idx != idx_q) ||
            (op_write && (pmem_wdata != wdata_q))) begin
          err_d = 1'b1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        // Counter reaching zero after this decrement ends the wait.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          if (!op_write) begin
            rdata_d = arr_rdata;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        if (op_write) begin
          arr_we   = !rst;   // no commit if reset lands on the response cycle
          wr_cnt_d = wr_cnt_q + 32'd1;
        end else begin
          rd_cnt_d = rd_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  assign pmem_resp  = (state_q == ST_RESP);
  assign pmem_rdata = rdata_q;
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;
  assign proto_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmem_responder
//  Purpose  : Self-checking bench for pmem_responder. Two instances:
//             d=0 with read/write latency 4/4, d=1 with latency 1/3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_responder;
  import pmem_pkg::*;

  localparam int ND = 2;
  localparam int NL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]       addr   [ND];
  logic [LINE_W-1:0] wdata  [ND];
  logic              rd     [ND];
  logic              wr     [ND];
  logic [LINE_W-1:0] rdata  [ND];
  logic              resp   [ND];
  logic [31:0]       rdc    [ND];
  logic [31:0]       wrc    [ND];
  logic              perr   [ND];

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    pmem_responder #(
      .NUM_LINES     (NL),
      .READ_LATENCY  ((gi == 0) ? 4 : 1),
      .WRITE_LATENCY ((gi == 0) ? 4 : 3)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .pmem_address (addr[gi]),
      .pmem_wdata   (wdata[gi]),
      .pmem_read    (rd[gi]),
      .pmem_write   (wr[gi]),
      .pmem_rdata   (rdata[gi]),
      .pmem_resp    (resp[gi]),
      .rd_count     (rdc[gi]),
      .wr_count     (wrc[gi]),
      .proto_err    (perr[gi])
    );
  end

  function automatic int rl(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int wl(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  // ---------------- reference model ----------------
  pmem_line_t  mm     [ND][NL];
  pmem_line_t  mrdata [ND];
  int unsigned mrd    [ND];
  int unsigned mwr    [ND];
  logic        merr   [ND];
  bit          in_resp[ND];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic pmem_line_t rnd_line();
    pmem_line_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % NL);
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0;
    end
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      mrd[d] = 0; mwr[d] = 0; merr[d] = 1'b0; mrdata[d] = '0; in_resp[d] = 1'b0;
    end
  endtask

  task automatic check_reset(input int d);
    check("rst_resp",  256'(resp[d]), 256'(0));
    check("rst_rdata", rdata[d], '0);
    check("rst_rdcnt", 256'(rdc[d]), 256'(0));
    check("rst_wrcnt", 256'(wrc[d]), 256'(0));
    check("rst_err",   256'(perr[d]), 256'(0));
  endtask

  task automatic idle(input int d, input int n);
    rd[d] = 1'b0; wr[d] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    if (n > 0) in_resp[d] = 1'b0;
  endtask

  // Presents one request and follows it to its response. If called in the
  // response cycle of the previous transaction the request is back-to-back
  // and is expected one cycle later.
  task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                     input pmem_line_t dat, input bit glitch);
    int lat, k, exp_k, li;
    lat   = w ? wl(d) : rl(d);
    exp_k = lat + (in_resp[d] ? 1 : 0);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = dat;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (glitch && k == 1) addr[d] = a ^ 32'h20;
    end while (resp[d] !== 1'b1 && k < 20);
    check("resp_latency", 256'(k), 256'(exp_k));
    li = line_of(a);
    if (r && w) merr[d] = 1'b1;
    if (glitch) merr[d] = 1'b1;
    if (!w) mrdata[d] = mm[d][li];
    check("rdata", rdata[d], mrdata[d]);
    check("err", 256'(perr[d]), 256'(merr[d]));
    check("rdcnt_pre", 256'(rdc[d]), 256'(mrd[d]));
    check("wrcnt_pre", 256'(wrc[d]), 256'(mwr[d]));
    if (w) begin
      mm[d][li] = dat;
      mwr[d]++;
    end else begin
      mrd[d]++;
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    in_resp[d] = 1'b1;
  endtask

  task automatic check_counts(input int d);
    check("rdcnt", 256'(rdc[d]), 256'(mrd[d]));
    check("wrcnt", 256'(wrc[d]), 256'(mwr[d]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    pmem_line_t p, old;
    logic [31:0] a;
    bit saw;
    for (int d = 0; d < ND; d++) begin
      addr[d] = '0; wdata[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
    end

    for (int d = 0; d < ND; d++) begin
      do_reset(3);
      check_reset(d);

      // fill every line so later reads have known contents
      for (int i = 0; i < NL; i++) begin
        a = ($urandom & ~32'h0000_01E0) | 32'(i << 5);
        txn(d, 1'b0, 1'b1, a, rnd_line(), 1'b0);
        idle(d, 1);
      end
      check_counts(d);

      // write then read same line
      txn(d, 1'b0, 1'b1, 32'h0000_0040, {32{8'hA5}}, 1'b0);
      idle(d, 2);
      txn(d, 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0);
      idle(d, 1);
      check("a5_read", rdata[d], {32{8'hA5}});

      // aliasing and ignored offset bits
      p = rnd_line();
      txn(d, 1'b0, 1'b1, 32'h0000_0000, p, 1'b0);
      idle(d, 1);
      txn(d, 1'b1, 1'b0, 32'h0000_0200, '0, 1'b0);
      idle(d, 1);
      txn(d, 1'b1, 1'b0, 32'h0000_001F, '0, 1'b0);
      idle(d, 1);
      check("alias_read", rdata[d], p);

      // back-to-back write then read of the same line, then a read burst
      p = rnd_line();
      txn(d, 1'b0, 1'b1, 32'h0000_00A0, p, 1'b0);
      txn(d, 1'b1, 1'b0, 32'h0000_00A0, '0, 1'b0);
      for (int i = 0; i < 4; i++) txn(d, 1'b1, 1'b0, 32'($urandom), '0, 1'b0);
      idle(d, 1);
      check_counts(d);

      // randomized traffic with random gaps
      for (int i = 0; i < 40; i++) begin
        bit w;
        int gap;
        w   = 1'($urandom_range(0, 1));
        gap = int'($urandom_range(0, 2));
        if (gap > 0) idle(d, gap);
        txn(d, !w, w, 32'($urandom), rnd_line(), 1'b0);
      end
      idle(d, 1);
      check_counts(d);

      // read and write together: serviced as write, sticky error
      txn(d, 1'b1, 1'b1, 32'h0000_0060, rnd_line(), 1'b0);
      idle(d, 1);
      txn(d, 1'b1, 1'b0, 32'h0000_0060, '0, 1'b0);
      idle(d, 3);
      check("err_sticky", 256'(perr[d]), 256'(1));
      check_counts(d);

      // address moved while busy: original line still completes
      do_reset(1);
      check_reset(d);
      txn(d, 1'b0, 1'b1, 32'h0000_0080, rnd_line(), 1'b1);
      idle(d, 1);
      txn(d, 1'b1, 1'b0, 32'h0000_0080, '0, 1'b0);
      idle(d, 1);

      // reset in the second busy cycle of a write to line 3
      do_reset(1);
      old = mm[d][3];
      rd[d] = 1'b0; wr[d] = 1'b1; addr[d] = 32'h0000_0060; wdata[d] = ~old;
      saw = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
        saw |= resp[d];
      end
      rst = 1'b1; wr[d] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
        saw |= resp[d];
        @(posedge clk); #1;
      end
      check("abort_no_resp", 256'(saw), 256'(0));
      mrd[d] = 0; mwr[d] = 0; merr[d] = 1'b0; mrdata[d] = '0; in_resp[d] = 1'b0;
      check_reset(d);
      txn(d, 1'b1, 1'b0, 32'h0000_0060, '0, 1'b0);
      idle(d, 1);
      check("abort_old_line", rdata[d], old);
      check_counts(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
